// File: rtl/pc_fetch.sv
// Fetch stage: owns the program counter, drives instruction memory, and
// hands latched instruction words to decode over a valid/ready handshake.
// Branch, jump and jump-register redirects squash one fetched word, and a
// halt opcode stops fetching until reset.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] immExt,
  input  logic [25:0] jTarget,
  input  logic [31:0] rsData,
  input  logic [31:0] IDataIn,
  input  logic        decReady,
  output logic [31:0] IAddr,
  output logic        RW,
  output logic [31:0] IR,
  output logic [31:0] PC4,
  output logic        irValid,
  output logic        halted
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] ir_r, ir_nxt_s;
  logic [31:0] pc4_r, pc4_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        halted_r, halted_nxt_s;

  logic        fire_s;
  logic        redirect_s;
  logic        load_s;
  logic [31:0] target_s;
  logic [31:0] seq_pc_s;

  // Redirect target relative to the consumed instruction's PC+4 (all mod 2^32).
  function automatic logic [31:0] redirect_target(
    input logic [1:0]  sel,
    input logic [31:0] pc4,
    input logic [31:0] imm,
    input logic [25:0] jt,
    input logic [31:0] rs
  );
    logic [31:0] t;
    case (sel)
      2'b01:   t = pc4 + (imm << 2);
      2'b10:   t = {pc4[31:28], jt, 2'b00};
      2'b11:   t = rs & 32'hFFFF_FFFC;
      default: t = pc4;
    endcase
    return t;
  endfunction

  // Handshake and control decisions for the current cycle.
  always_comb begin
    fire_s     = valid_r && decReady;
    redirect_s = fire_s && (PCSrc != 2'b00) && (state_r == ST_RUN);
    load_s     = (state_r == ST_RUN) && PCWre && (!valid_r || decReady) && !redirect_s;
    target_s   = redirect_target(PCSrc, pc4_r, immExt, jTarget, rsData);
    seq_pc_s   = pc_r + 32'd4;
  end

  // Next-state selection: redirect > load > fire-only > hold.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    ir_nxt_s     = ir_r;
    pc4_nxt_s    = pc4_r;
    valid_nxt_s  = valid_r;
    halted_nxt_s = halted_r;
    if (redirect_s) begin
      // The word fetched this cycle is dropped: exactly one bubble.
      pc_nxt_s    = target_s;
      valid_nxt_s = 1'b0;
    end else if (load_s) begin
      ir_nxt_s    = IDataIn;
      pc4_nxt_s   = seq_pc_s;
      pc_nxt_s    = seq_pc_s;
      valid_nxt_s = 1'b1;
      if (IDataIn[31:26] == HALT_OP) begin
        // Halt word is still delivered; fetching stops from the next cycle.
        state_nxt_s  = ST_HALT;
        halted_nxt_s = 1'b1;
      end else begin
        state_nxt_s  = state_r;
      end
    end else if (fire_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_r  <= ST_RUN;
      pc_r     <= RESET_PC;
      ir_r     <= 32'h0000_0000;
      pc4_r    <= 32'h0000_0000;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      ir_r     <= ir_nxt_s;
      pc4_r    <= pc4_nxt_s;
      valid_r  <= valid_nxt_s;
      halted_r <= halted_nxt_s;
    end
  end

  assign IAddr   = pc_r;
  assign RW      = Reset && (state_r == ST_RUN);
  assign IR      = ir_r;
  assign PC4     = pc4_r;
  assign irValid = valid_r;
  assign halted  = halted_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed stimulus pushes the expected
// (IR, PC4) deliveries into a queue; a monitor pops and compares on every
// decode handshake. Direct checks cover address, read enable and halt.
module tb_pc_fetch;

  logic        CLK;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] immExt;
  logic [25:0] jTarget;
  logic [31:0] rsData;
  logic [31:0] IDataIn;
  logic        decReady;
  logic [31:0] IAddr;
  logic        RW;
  logic [31:0] IR;
  logic [31:0] PC4;
  logic        irValid;
  logic        halted;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  pc_fetch dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
    .immExt(immExt), .jTarget(jTarget), .rsData(rsData),
    .IDataIn(IDataIn), .decReady(decReady), .IAddr(IAddr), .RW(RW),
    .IR(IR), .PC4(PC4), .irValid(irValid), .halted(halted)
  );

  // Clock, 10 time-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory contents: halt opcode at 12, address-tagged words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd12) return 32'hFC00_0000;
    return {6'b000010, a[27:2]};
  endfunction

  // Combinational instruction memory.
  always_comb IDataIn = mem_word(IAddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic expect_word(input logic [31:0] addr);
    exp_t e;
    e.ir  = mem_word(addr);
    e.pc4 = addr + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every handshake must match the oldest expected delivery.
  always @(negedge CLK) begin
    if (irValid && decReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", IR, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_ir", IR, e.ir);
        chk("sb_pc4", PC4, e.pc4);
      end
    end
  end

  initial begin
    Reset = 1'b0; PCWre = 1'b1; PCSrc = 2'b00; immExt = 32'd0;
    jTarget = 26'd0; rsData = 32'd0; decReady = 1'b1;

    // Reset state
    step(); step();
    chk("rst_iaddr", IAddr, 32'h0);
    chk("rst_rw", {31'd0, RW}, 32'd0);
    chk("rst_valid", {31'd0, irValid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_pc4", PC4, 32'h0);
    Reset = 1'b1;
    #1;
    chk("run_rw", {31'd0, RW}, 32'd1);
    expect_word(32'd0); expect_word(32'd4); expect_word(32'd8);

    // Sequential fetch 0,4,8
    step();
    chk("seq_iaddr4", IAddr, 32'd4);
    chk("seq_ir0", IR, mem_word(32'd0));
    chk("seq_pc4_4", PC4, 32'd4);
    chk("seq_valid", {31'd0, irValid}, 32'd1);
    step();
    chk("seq_iaddr8", IAddr, 32'd8);
    step();
    chk("seq_iaddr12", IAddr, 32'd12);
    chk("seq_pc4_12", PC4, 32'd12);

    // Branch back by two words from PC4=12
    PCSrc = 2'b01; immExt = 32'hFFFF_FFFE;
    step();
    chk("br_iaddr", IAddr, 32'd4);
    chk("br_bubble", {31'd0, irValid}, 32'd0);
    PCSrc = 2'b00; immExt = 32'd0;
    expect_word(32'd4);
    step();
    chk("br_refill_valid", {31'd0, irValid}, 32'd1);
    chk("br_iaddr_next", IAddr, 32'd8);

    // jr to 0x4000_000C (low bits ignored)
    PCSrc = 2'b11; rsData = 32'h4000_000F;
    step();
    chk("jr1_iaddr", IAddr, 32'h4000_000C);
    PCSrc = 2'b00;
    expect_word(32'h4000_000C);
    step();
    chk("jr1_pc4", PC4, 32'h4000_0010);

    // Jump from PC4=0x4000_0010
    PCSrc = 2'b10; jTarget = 26'h0000040;
    step();
    chk("j_iaddr", IAddr, 32'h4000_0100);
    chk("j_bubble", {31'd0, irValid}, 32'd0);
    PCSrc = 2'b00;
    expect_word(32'h4000_0100);
    step();

    // jr with misaligned register value
    PCSrc = 2'b11; rsData = 32'h0000_0203;
    step();
    chk("jr2_iaddr", IAddr, 32'h0000_0200);
    PCSrc = 2'b00;
    expect_word(32'h0000_0200);
    step();
    chk("jr2_ir", IR, mem_word(32'h200));

    // Back-pressure: IR, PC4, PC hold and RW stays high
    decReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_ir", IR, mem_word(32'h200));
      chk("bp_pc4", PC4, 32'h204);
      chk("bp_iaddr", IAddr, 32'h204);
      chk("bp_rw", {31'd0, RW}, 32'd1);
      chk("bp_valid", {31'd0, irValid}, 32'd1);
    end

    // Stall for 3 cycles: pending fire drains IR, PC holds
    decReady = 1'b1; PCWre = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_iaddr", IAddr, 32'h204);
      chk("stall_ir", IR, mem_word(32'h200));
      chk("stall_valid", {31'd0, irValid}, 32'd0);
    end
    PCWre = 1'b1;
    expect_word(32'h204);
    step();
    chk("stall_resume_iaddr", IAddr, 32'h208);

    // Wrap-around via jr to 0xFFFF_FFFC
    PCSrc = 2'b11; rsData = 32'hFFFF_FFFC;
    step();
    chk("wrap_jr_iaddr", IAddr, 32'hFFFF_FFFC);
    PCSrc = 2'b00;
    expect_word(32'hFFFF_FFFC);
    step();
    chk("wrap_iaddr", IAddr, 32'h0);
    chk("wrap_pc4", PC4, 32'h0);

    // Run into the halt word at 12
    expect_word(32'd0); expect_word(32'd4); expect_word(32'd8); expect_word(32'd12);
    step(); step(); step();
    chk("pre_halt_iaddr", IAddr, 32'd12);
    step();
    chk("halt_ir", IR, 32'hFC00_0000);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_rw", {31'd0, RW}, 32'd0);
    chk("halt_iaddr", IAddr, 32'd16);
    chk("halt_valid", {31'd0, irValid}, 32'd1);
    PCSrc = 2'b10; jTarget = 26'h0000040;
    step();
    chk("halt_jmp_ignored", IAddr, 32'd16);
    chk("halt_drained", {31'd0, irValid}, 32'd0);
    step();
    chk("halt_frozen", IAddr, 32'd16);
    chk("halt_still", {31'd0, halted}, 32'd1);
    PCSrc = 2'b00;

    // Reset out of halt, then reset again during a redirect
    Reset = 1'b0;
    step();
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_iaddr", IAddr, 32'h0);
    Reset = 1'b1;
    expect_word(32'd0);
    step();
    chk("rst2_ir", IR, mem_word(32'd0));
    PCSrc = 2'b01; immExt = 32'd5; Reset = 1'b0;
    step();
    chk("rst_mid_iaddr", IAddr, 32'h0);
    chk("rst_mid_valid", {31'd0, irValid}, 32'd0);
    chk("rst_mid_halted", {31'd0, halted}, 32'd0);
    PCSrc = 2'b00; immExt = 32'd0; decReady = 1'b0; Reset = 1'b1;
    step();
    chk("final_ir", IR, mem_word(32'd0));
    step();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory address and read control (IAddr, RW).
- Latches the returned 32-bit word into an instruction register and hands it to decode over a valid/ready handshake.
- Applies branch, jump and jump-register redirects with a one-bubble squash, and stops fetching on a halt opcode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode (instruction bits [31:26]) that halts fetch.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset.
- PCWre  input  1  PC write enable; 0 stalls fetch.
- PCSrc  input  2  next-PC select for the instruction being consumed: 00 seq, 01 branch, 10 jump, 11 jr.
- immExt  input  32  sign-extended branch offset (word units).
- jTarget  input  26  jump target field.
- rsData  input  32  register value for jr.
- IDataIn  input  32  instruction word returned by instruction memory for IAddr.
- decReady  input  1  decode accepts IR this cycle.
- IAddr  output  32  byte address to instruction memory; equals PC (combinational).
- RW  output  1  instruction memory read enable; 1 = read.
- IR  output  32  registered instruction.
- PC4  output  32  registered address-of-IR + 4.
- irValid  output  1  IR holds an unconsumed instruction.
- halted  output  1  fetch stopped by halt opcode.

Behaviour:
- Reset (Reset==0 at a rising edge) dominates everything:
  - PC<=RESET_PC, IR<=0, PC4<=0, irValid<=0, halted<=0, state<=RUN.
  - RW=0 while Reset==0.
- States: RUN, HALT. RW = Reset && (state==RUN).
- Derived signals:
  - fire = irValid && decReady.
  - redirect = fire && (PCSrc!=00) && state==RUN.
  - load = state==RUN && PCWre && (!irValid || decReady) && !redirect.
- Redirect targets, computed from registered PC4, all mod 2^32:
  - 01: PC4 + (immExt<<2).
  - 10: {PC4[31:28], jTarget, 2'b00}.
  - 11: {rsData[31:2], 2'b00}.
- Priority per edge: redirect > load > fire-only > hold.
- On redirect:
  - PC<=target, irValid<=0; IR and PC4 hold.
  - The word fetched that cycle is discarded (exactly one bubble).
  - Applies regardless of PCWre.
- On load:
  - IR<=IDataIn, PC4<=PC+4, PC<=PC+4, irValid<=1.
  - If IDataIn[31:26]==HALT_OP: state<=HALT and halted<=1 on the same edge.
  - The halt word itself is still delivered in IR.
- Fire without load or redirect: irValid<=0.
- Stall (PCWre==0, no redirect): PC and IR hold; a pending fire still clears irValid.
- Back-pressure (irValid==1, decReady==0): PC, IR and PC4 all hold; RW stays 1.
- Wrap-around: PC=32'hFFFF_FFFC, sequential load gives PC=0 and PC4=0.
- PC[1:0] is always 00 by construction.
- HALT state:
  - RW=0, no loads, PC frozen, redirect ignored, halted=1.
  - Remaining IR drains on fire.
  - Exit only via Reset.
- Latency: address presented in cycle n; instruction visible on IR with irValid=1 in cycle n+1.

Test Plan:
- Reset low 2 cycles then high; memory holds words at 0,4,8 with decReady=1 and PCSrc=00 -> IAddr 0,4,8,... each cycle; IR shows word@0 one cycle after IAddr=0; PC4=4 alongside it; RW=1.
- Branch: IR at addr 8 (PC4=12), PCSrc=01, immExt=-2 -> next IAddr=4; exactly one cycle with irValid=0; word@12 never presented as valid.
- Jump and jr: PC4=32'h4000_0010, jTarget=26'h0000040 -> IAddr=32'h4000_0100. jr with rsData=32'h0000_0203 -> IAddr=32'h0000_0200.
- Stall and back-pressure:
  - PCWre=0 for 3 cycles -> IAddr constant; IR unchanged; irValid drops after first fire.
  - decReady=0 with irValid=1 -> IR, PC and PC4 hold.
- Halt: word 32'hFC00_0000 at addr 12 -> it appears in IR; halted=1 and RW=0 the same edge; PC frozen at 16; PCSrc=10 afterwards ignored.
- Wrap and reset mid-run: PC=32'hFFFF_FFFC sequential -> IAddr=0. Reset low mid-redirect -> PC=RESET_PC, irValid=0, halted=0 next edge.
